sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 92 +++++++++
 tb/tb_sram_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// 32-bit load/store bridge onto a 16-bit asynchronous SRAM: each access is split into
// a low and a high halfword transfer, then padded by WAIT_CYCLES idle cycles.
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, LO, HI, PAD, DONE} stateT;

   stateT            state;
   logic [CNT_W-1:0] padCnt;
   logic [16:0]      waddr;
   logic [31:0]      data;
   logic             opWrite;
   logic [16:0]      reqWaddr;
   logic             request;

   assign request  = wr_en || rd_en;
   assign reqWaddr = 17'((address - BASE_ADDR) >> 2);
   assign ready    = (state == DONE) || ((state == IDLE) && !request);

   // Bus outputs are registered one state ahead so they are stable for the whole LO/HI cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         padCnt      <= '0;
         waddr       <= '0;
         data        <= '0;
         opWrite     <= 1'b0;
         readData    <= '0;
         SRAM_ADDR   <= '0;
         SRAM_WE_N   <= 1'b1;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  waddr       <= reqWaddr;
                  data        <= writeData;
                  opWrite     <= wr_en;
                  SRAM_ADDR   <= {reqWaddr, 1'b0};
                  SRAM_WE_N   <= !wr_en;
                  sram_dq_oe  <= wr_en;
                  sram_dq_out <= wr_en ? writeData[15:0] : '0;
                  state       <= LO;
               end
            end
            LO: begin
               if (!opWrite) readData[15:0] <= sram_dq_in;
               SRAM_ADDR   <= {waddr, 1'b1};
               SRAM_WE_N   <= !opWrite;
               sram_dq_oe  <= opWrite;
               sram_dq_out <= opWrite ? data[31:16] : '0;
               state       <= HI;
            end
            HI: begin
               if (!opWrite) readData[31:16] <= sram_dq_in;
               SRAM_WE_N   <= 1'b1;
               sram_dq_oe  <= 1'b0;
               sram_dq_out <= '0;
               padCnt      <= PAD_LAST;
               state       <= (WAIT_CYCLES == 0) ? DONE : PAD;
            end
            PAD: begin
               if (padCnt == '0) state <= DONE;
               else padCnt <= padCnt - 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed plus randomized bench for sram_controller against a word-level memory model
// and a halfword SRAM model; also exercises a WAIT_CYCLES=0 build.
module tb_sram_controller;

   localparam int unsigned BASE = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wrEn = 1'b0, rdEn = 1'b0;
   logic [31:0] address = '0, writeData = '0;
   logic [31:0] readData;
   logic        ready;
   logic [17:0] sramAddr;
   logic        sramWeN;
   logic [15:0] sramDqOut;
   logic        sramDqOe;
   logic [15:0] sramDqIn;

   logic        rdEn0 = 1'b0;
   logic [31:0] address0 = '0;
   logic [31:0] readData0;
   logic        ready0;
   logic [17:0] sramAddr0;
   logic        sramWeN0;
   logic [15:0] sramDqOut0;
   logic        sramDqOe0;
   logic [15:0] sramDqIn0;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [31:0] refMem [int unsigned];
   logic [31:0] lastRead = '0;
   logic [15:0] sramMem [256] = '{default: '0};

   sram_controller dut (
      .clk(clk), .rst(rst), .wr_en(wrEn), .rd_en(rdEn), .address(address),
      .writeData(writeData), .readData(readData), .ready(ready), .SRAM_ADDR(sramAddr),
      .SRAM_WE_N(sramWeN), .sram_dq_out(sramDqOut), .sram_dq_oe(sramDqOe), .sram_dq_in(sramDqIn)
   );

   sram_controller #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .wr_en(1'b0), .rd_en(rdEn0), .address(address0),
      .writeData(32'h0), .readData(readData0), .ready(ready0), .SRAM_ADDR(sramAddr0),
      .SRAM_WE_N(sramWeN0), .sram_dq_out(sramDqOut0), .sram_dq_oe(sramDqOe0), .sram_dq_in(sramDqIn0)
   );

   always #5 clk = ~clk;

   assign sramDqIn  = sramMem[sramAddr[7:0]];
   assign sramDqIn0 = sramAddr0[15:0];

   always @(posedge clk) if (!sramWeN && sramDqOe) sramMem[sramAddr[7:0]] <= sramDqOut;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] refRead(input int unsigned w);
      return refMem.exists(w) ? refMem[w] : 32'h0;
   endfunction

   task automatic idleGap();
      @(posedge clk); #1;
      check("readyIdle", {31'd0, ready}, 32'd1);
   endtask

   // Call just after a rising edge with the controller in IDLE; returns at the DONE negedge.
   task automatic doAccess(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] dat, input bit keep);
      int unsigned w = (addr - BASE) >> 2;
      bit          isWrite = wr;
      logic [31:0] word;
      int unsigned n = 0;
      wrEn = wr; rdEn = rd; address = addr; writeData = dat;
      word = isWrite ? dat : refRead(w);
      @(negedge clk);
      check("readyOnRequest", {31'd0, ready}, 32'd0);
      do begin
         @(posedge clk); @(negedge clk); n++;
         if (n == 1 || n == 2) begin
            check("sramAddr", {14'd0, sramAddr}, 32'(2 * w + n - 1));
            check("weN", {31'd0, sramWeN}, {31'd0, !isWrite});
            check("dqOe", {31'd0, sramDqOe}, {31'd0, isWrite});
            check("dqOut", {16'd0, sramDqOut},
                  isWrite ? ((n == 1) ? {16'd0, word[15:0]} : {16'd0, word[31:16]}) : 32'd0);
         end else if (!ready) begin
            check("padWeN", {31'd0, sramWeN}, 32'd1);
            check("padOe", {31'd0, sramDqOe}, 32'd0);
            check("padDqOut", {16'd0, sramDqOut}, 32'd0);
         end
      end while (!ready && n < 20);
      check("latency", n, 32'd6);
      if (isWrite) begin
         refMem[w] = dat;
         check("readDataHeld", readData, lastRead);
      end else begin
         lastRead = word;
         check("readData", readData, word);
      end
      if (!keep) begin
         wrEn = 1'b0; rdEn = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      int unsigned n;
      int unsigned op;

      // reset values
      repeat (2) @(negedge clk);
      check("rstReadData", readData, 32'd0);
      check("rstSramAddr", {14'd0, sramAddr}, 32'd0);
      check("rstWeN", {31'd0, sramWeN}, 32'd1);
      check("rstOe", {31'd0, sramDqOe}, 32'd0);
      check("rstDqOut", {16'd0, sramDqOut}, 32'd0);
      check("rstReady", {31'd0, ready}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;

      doAccess(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
      idleGap();
      doAccess(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
      idleGap();
      doAccess(1'b1, 1'b1, 32'd1028, 32'h12345678, 1'b0);
      idleGap();
      doAccess(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
      idleGap();

      // back-to-back reads with the request held through DONE
      doAccess(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
      address = 32'd1032;
      @(posedge clk); #1;
      doAccess(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
      idleGap();

      // reset during the HI phase of a write to word 4
      d = $urandom;
      wrEn = 1'b1; address = 32'd1040; writeData = d;
      @(posedge clk); @(posedge clk); #2;
      check("hiWeN", {31'd0, sramWeN}, 32'd0);
      rst = 1'b0;
      #1;
      check("abortWeN", {31'd0, sramWeN}, 32'd1);
      check("abortOe", {31'd0, sramDqOe}, 32'd0);
      check("abortReady", {31'd0, ready}, 32'd0);
      check("abortReadData", readData, 32'd0);
      refMem[4] = {refRead(4)[31:16], d[15:0]};
      lastRead = '0;
      wrEn = 1'b0;
      @(negedge clk);
      check("abortReadyIdle", {31'd0, ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      doAccess(1'b1, 1'b0, 32'd1060, 32'hCAFEF00D, 1'b0);
      idleGap();
      doAccess(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
      idleGap();

      // WAIT_CYCLES=0 build: three-cycle latency
      rdEn0 = 1'b1; address0 = BASE + 40;
      @(negedge clk);
      check("w0ReadyOnRequest", {31'd0, ready0}, 32'd0);
      n = 0;
      do begin
         @(posedge clk); @(negedge clk); n++;
      end while (!ready0 && n < 20);
      check("w0Latency", n, 32'd3);
      check("w0ReadData", readData0, {16'd21, 16'd20});
      check("w0SramAddr", {14'd0, sramAddr0}, 32'd21);
      check("w0WeN", {31'd0, sramWeN0}, 32'd1);
      check("w0Oe", {31'd0, sramDqOe0}, 32'd0);
      check("w0DqOut", {16'd0, sramDqOut0}, 32'd0);
      rdEn0 = 1'b0;
      idleGap();

      // randomized traffic
      for (int i = 0; i < 24; i++) begin
         op = $urandom_range(0, 2);
         a  = BASE + $urandom_range(0, 255);
         d  = $urandom;
         doAccess(op != 1, op != 0, a, d, 1'b0);
         idleGap();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
